ir_fetch: RTL and testbench

IR_FETCH -- requirements
Module: ir_fetch

---
 rtl/ir_fetch.sv | 149 ++++++++++++++
 tb/tb_ir_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ir_fetch.sv
// ir_fetch -- instruction fetch unit with a two-state request FSM.
//
// The unit fetches one instruction word at the current PC whenever the
// controller pulses `fetch` while idle. It then holds a memory read request
// until the memory acknowledges. On that acknowledge the word is latched into
// the instruction register (IR) and the PC advances by 4, wrapping at 2^32.
// The decoded IR fields are plain combinational slices of the IR.
//
// Optional feature (macro IF_TIMEOUT_EN):
//   When the macro is defined, a 4-bit counter watches for request cycles
//   that get no acknowledge. On the 16th such cycle the request is abandoned
//   and the sticky bus_err flag is set. The flag is cleared by reset or by
//   the next accepted fetch. When the macro is undefined, a request waits
//   indefinitely and bus_err is tied low.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active low
//   fetch      in   request a fetch at the current PC (ignored while busy)
//   pc_wr      in   load pc_next into PC (honoured only while idle)
//   pc_next    in   [31:0] new PC; bits [1:0] are forced to zero
//   mem_req    out  memory read request
//   mem_addr   out  [31:0] read address (= pc)
//   mem_ack    in   read data valid this cycle
//   mem_rdata  in   [31:0] instruction word
//   pc         out  [31:0] current PC
//   inst       out  [31:0] instruction register
//   op/rs/rt/rd/shamt/funct  out  IR fields [31:26]/[25:21]/[20:16]/[15:11]/[10:6]/[5:0]
//   imm_16     out  [15:0] IR[15:0]
//   ir_valid   out  one-cycle pulse after the IR has been loaded
//   busy       out  a fetch is outstanding
//   bus_err    out  sticky fetch-timeout flag
module ir_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch,
    input  logic        pc_wr,
    input  logic [31:0] pc_next,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm_16,
    output logic        ir_valid,
    output logic        busy,
    output logic        bus_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    // PCs are always word aligned; the mask is also applied to RESET_PC.
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [0:0]  state_reg;
    logic [31:0] pc_reg;
    logic [31:0] ir_reg;
    logic        ir_valid_reg;

`ifdef IF_TIMEOUT_EN
    logic [3:0]  timeout_cnt_reg;
    logic        bus_err_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_PC & WORD_MASK;
            ir_reg          <= 32'h0;
            ir_valid_reg    <= 1'b0;
`ifdef IF_TIMEOUT_EN
            timeout_cnt_reg <= 4'h0;
            bus_err_reg     <= 1'b0;
`endif
        end else begin
            ir_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // A PC load and a fetch in the same cycle are both
                    // honoured. The request starts next cycle from pc_reg,
                    // so it naturally uses the freshly loaded value.
                    if (pc_wr) begin
                        pc_reg <= pc_next & WORD_MASK;
                    end
                    if (fetch) begin
                        state_reg       <= ST_REQ;
`ifdef IF_TIMEOUT_EN
                        timeout_cnt_reg <= 4'h0;
                        bus_err_reg     <= 1'b0;
`endif
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        ir_reg       <= mem_rdata;
                        pc_reg       <= pc_reg + 32'd4;
                        ir_valid_reg <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end else begin
`ifdef IF_TIMEOUT_EN
                        // A count of 15 means this is the 16th unanswered
                        // cycle. Give up and leave PC and IR untouched.
                        if (timeout_cnt_reg == 4'hF) begin
                            state_reg       <= ST_IDLE;
                            bus_err_reg     <= 1'b1;
                            timeout_cnt_reg <= 4'h0;
                        end else begin
                            timeout_cnt_reg <= timeout_cnt_reg + 4'h1;
                        end
`endif
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign mem_req  = (state_reg == ST_REQ);
    assign busy     = (state_reg == ST_REQ);
    assign mem_addr = pc_reg;
    assign pc       = pc_reg;
    assign inst     = ir_reg;
    assign ir_valid = ir_valid_reg;

    assign op     = ir_reg[31:26];
    assign rs     = ir_reg[25:21];
    assign rt     = ir_reg[20:16];
    assign rd     = ir_reg[15:11];
    assign shamt  = ir_reg[10:6];
    assign funct  = ir_reg[5:0];
    assign imm_16 = ir_reg[15:0];

`ifdef IF_TIMEOUT_EN
    assign bus_err = bus_err_reg;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_ir_fetch.sv
// tb_ir_fetch -- self-checking bench for ir_fetch.
// The bench runs directed scenarios with literal expectations, followed by
// randomized stimulus. A transaction-level reference model tracks the state,
// and a compare process checks every output on each falling edge.
// Define IF_TIMEOUT_EN to also exercise the timeout path.
module tb_ir_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] MASK     = 32'hFFFF_FFFC;
`ifdef IF_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch, pc_wr, mem_ack;
    logic [31:0] pc_next, mem_rdata;
    logic        mem_req, ir_valid, busy, bus_err;
    logic [31:0] mem_addr, pc, inst;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm_16;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ir_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .fetch(fetch), .pc_wr(pc_wr), .pc_next(pc_next),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .pc(pc), .inst(inst), .op(op), .rs(rs),
        .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm_16(imm_16),
        .ir_valid(ir_valid), .busy(busy), .bus_err(bus_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding fetch, with its address and wait time.
    bit          m_busy, m_valid, m_err;
    logic [31:0] m_pc, m_ir, m_addr;
    int          m_wait;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            m_pc    <= RESET_PC;
            m_ir    <= 32'h0;
            m_addr  <= RESET_PC;
            m_wait  <= 0;
        end else begin
            m_valid <= 1'b0;
            if (!m_busy) begin
                if (pc_wr) m_pc <= pc_next & MASK;
                if (fetch) begin
                    m_busy <= 1'b1;
                    m_addr <= pc_wr ? (pc_next & MASK) : m_pc;
                    m_wait <= 0;
                    m_err  <= 1'b0;
                end
            end else if (mem_ack) begin
                m_ir    <= mem_rdata;
                m_pc    <= m_addr + 32'd4;
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
            end else begin
                m_wait <= m_wait + 1;
                if (TO_EN && (m_wait + 1 == 16)) begin
                    m_busy <= 1'b0;
                    m_err  <= 1'b1;
                end
            end
        end
    end

    // Compare process: all outputs are registered, so the falling edge is a
    // stable sampling point.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req",  {31'b0, mem_req},  {31'b0, m_busy});
            chk("busy",     {31'b0, busy},     {31'b0, m_busy});
            chk("mem_addr", mem_addr, m_busy ? m_addr : m_pc);
            chk("pc",       pc,       m_pc);
            chk("inst",     inst,     m_ir);
            chk("op",       {26'b0, op},    (m_ir >> 26) & 32'h3F);
            chk("rs",       {27'b0, rs},    (m_ir >> 21) & 32'h1F);
            chk("rt",       {27'b0, rt},    (m_ir >> 16) & 32'h1F);
            chk("rd",       {27'b0, rd},    (m_ir >> 11) & 32'h1F);
            chk("shamt",    {27'b0, shamt}, (m_ir >> 6)  & 32'h1F);
            chk("funct",    {26'b0, funct}, m_ir & 32'h3F);
            chk("imm_16",   {16'b0, imm_16}, m_ir & 32'hFFFF);
            chk("ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
            chk("bus_err",  {31'b0, bus_err},  {31'b0, m_err});
        end
    end

    // Applies inputs, runs one clock, and returns at the following falling edge.
    task automatic drive(input logic f, input logic w, input logic [31:0] nx,
                         input logic a, input logic [31:0] rdat);
        fetch = f; pc_wr = w; pc_next = nx; mem_ack = a; mem_rdata = rdat;
        @(posedge clk);
        @(negedge clk);
    endtask

    int req_cnt, val_cnt;

    initial begin
        rst = 1'b0;
        fetch = 0; pc_wr = 0; pc_next = 0; mem_ack = 0; mem_rdata = 0;
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        chk_en = 1'b1;
        drive(0, 0, 0, 0, 0);
        chk("rst_pc",   pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        rst = 1'b1;

        // Fetch with the acknowledge in the first request cycle.
        drive(1, 0, 0, 0, 0);
        chk("t1_req",  {31'b0, mem_req}, 32'h1);
        chk("t1_addr", mem_addr, 32'h0);
        drive(0, 0, 0, 1, 32'h2008_FFFF);
        chk("t1_valid", {31'b0, ir_valid}, 32'h1);
        chk("t1_pc",    pc, 32'h4);
        chk("t1_op",    {26'b0, op}, 32'h08);
        chk("t1_rt",    {27'b0, rt}, 32'h8);
        chk("t1_imm",   {16'b0, imm_16}, 32'hFFFF);
        drive(0, 0, 0, 0, 0);
        chk("t1_pulse", {31'b0, ir_valid}, 32'h0);

        // Acknowledge delayed by 5 cycles; a second fetch during the wait is ignored.
        rst = 1'b0; drive(0, 0, 0, 0, 0); rst = 1'b1;
        req_cnt = 0; val_cnt = 0;
        drive(1, 0, 0, 0, 0);
        if (mem_req && mem_addr == 32'h0) req_cnt++;
        for (int i = 0; i < 5; i++) begin
            drive(i == 2, 0, 0, 0, 0);
            if (mem_req && mem_addr == 32'h0) req_cnt++;
        end
        drive(0, 0, 0, 1, 32'h1234_5678);
        if (ir_valid) val_cnt++;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0);
            if (ir_valid || mem_req) val_cnt++;
        end
        chk("t2_reqcyc", req_cnt, 6);
        chk("t2_valids", val_cnt, 1);
        chk("t2_inst",   inst, 32'h1234_5678);

        // PC load together with a fetch: the fetch uses the new, aligned PC.
        drive(1, 1, 32'h0000_0043, 0, 0);
        chk("t3_addr", mem_addr, 32'h0000_0040);
        drive(0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("t3_pc", pc, 32'h0000_0044);

        // PC wrap, then a reset during a request abandons it.
        drive(1, 1, 32'hFFFF_FFFC, 0, 0);
        drive(0, 0, 0, 1, 32'hCAFE_0001);
        chk("t4_wrap", pc, 32'h0);
        drive(1, 0, 0, 0, 0);
        rst = 1'b0; drive(0, 0, 0, 0, 0); rst = 1'b1;
        chk("t4_rstbusy", {31'b0, busy}, 32'h0);
        drive(0, 0, 0, 1, 32'h5555_AAAA);
        chk("t4_noval", {31'b0, ir_valid}, 32'h0);
        chk("t4_pc",    pc, RESET_PC);
        chk("t4_inst",  inst, 32'h0);

`ifdef IF_TIMEOUT_EN
        // Timeout after 16 unanswered request cycles.
        drive(1, 1, 32'h0000_0100, 0, 0);
        req_cnt = 0;
        if (mem_req) req_cnt++;
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 0);
            if (mem_req) req_cnt++;
        end
        chk("t5_reqcyc", req_cnt, 16);
        chk("t5_err",    {31'b0, bus_err}, 32'h1);
        chk("t5_pc",     pc, 32'h0000_0100);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h0BAD_F00D);
        chk("t5_clr",    {31'b0, bus_err}, 32'h0);
        chk("t5_pc2",    pc, 32'h0000_0104);
`endif

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) != 0);
            drive(logic'($urandom_range(0, 2) == 0),
                  logic'($urandom_range(0, 5) == 0),
                  $urandom,
                  logic'($urandom_range(0, 9) < 4),
                  $urandom);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
